ram_burst_ctrl: RTL and testbench
=================================

# ram_burst_ctrl

Request sequencer that sits directly upstream of the 8-entry × 8-bit RAM. It accepts burst write and burst read commands over a valid/ready interface and drives per-beat RAM strobes: address, write enable, read enable and write data. It captures RAM read data after a fixed latency and returns it one beat at a time over a back-pressured response channel. The RAM sees at most one access per cycle and never sees a write and a read in the same cycle.

## Interface
- DW, 8, data width of RAM words, write beats and response data.
- AW, 3, address width; the RAM depth is 2^AW, which is 8 entries.
- RD_LAT, 1, RAM read latency in cycles from the mem_re cycle to valid mem_rdata; legal range 1..4.

- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous active-low reset.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  the block can accept a command.
- cmd_wr  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  AW  start address of the burst.
- cmd_len  input  AW  number of beats minus 1; legal range 1..8 beats.
- w_valid  input  1  a write beat is presented.
- w_ready  output  1  the block can accept a write beat.
- w_data  input  DW  write beat data.
- rsp_valid  output  1  read data is presented.
- rsp_ready  input  1  the consumer accepts read data.
- rsp_data  output  DW  read beat data.
- mem_addr  output  AW  RAM address.
- mem_we  output  1  one-cycle RAM write strobe.
- mem_re  output  1  one-cycle RAM read strobe.
- mem_wdata  output  DW  RAM write data.
- mem_rdata  input  DW  RAM read data.
- busy  output  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, WRITE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1 when rst is high.
  - A handshake (cmd_valid & cmd_ready) latches cmd_addr into cur_addr and cmd_len into beats_left.
  - Next state is WRITE if cmd_wr = 1, otherwise ISSUE.
- WRITE:
  - w_ready = 1.
  - On each w handshake, the next cycle drives mem_we = 1, mem_addr = cur_addr and mem_wdata = w_data.
  - On each w handshake, cur_addr increments modulo 2^AW (7 wraps to 0).
  - The handshake on the last beat (beats_left = 0) returns the FSM to IDLE. Otherwise beats_left decrements.
- ISSUE: drives mem_re = 1 for exactly one cycle with mem_addr = cur_addr, then goes to WAIT.
- WAIT:
  - Counts RD_LAT cycles.
  - On the edge ending the WAIT count, rsp_data captures mem_rdata.
  - Next state is RESP.
- RESP:
  - rsp_valid = 1; rsp_data is held stable until rsp handshake.
  - On rsp handshake with beats_left = 0: next state IDLE.
  - On rsp handshake otherwise: cur_addr increments modulo 2^AW, beats_left decrements, next state ISSUE.
- cmd_ready = 0 and w_ready = 0 in every state other than the one that owns them.
  - w_valid outside WRITE is ignored.
  - A second command cannot be accepted until the FSM is back in IDLE.
- mem_we and mem_re are never high in the same cycle. Each is a one-cycle pulse per beat.
- mem_addr and mem_wdata hold their last values when no strobe is active.
- cmd_wr, cmd_addr and cmd_len are sampled only at the command handshake.
- Reset (rst low, any time, including mid-burst):
  - Immediate return to IDLE.
  - mem_we = mem_re = 0, rsp_valid = 0, busy = 0, mem_addr = 0, mem_wdata = 0, rsp_data = 0.
  - cmd_ready = 0 and w_ready = 0 while rst is low.
  - Any pending beat is dropped, with no RAM strobe after reset assertion.

## Timing
- Write beat: w handshake at cycle t produces the mem_we pulse at t+1.
  - Back-to-back beats are accepted every cycle.
  - An N-beat write occupies N cycles minimum.
- Write end: after the last-beat handshake at t, cmd_ready = 1 at t+1.
- Read beat: command accepted at t.
  - mem_re at t+1.
  - mem_rdata sampled at the end of cycle t+1+RD_LAT.
  - rsp_valid high at t+2+RD_LAT.
- Read throughput: with rsp_ready held high, one beat every RD_LAT+2 cycles.
- Read end: after the final rsp handshake at t, cmd_ready = 1 at t+1.
- rsp_valid never drops without a handshake, except on reset.

## Test plan
- Single write: addr=2, len=0, w_data=0xA5 → mem_we pulse one cycle after the beat handshake with mem_addr=2, mem_wdata=0xA5; cmd_ready returns the next cycle.
- Wrapping write burst: addr=6, len=3, data 0x11,0x22,0x33,0x44 → mem_we at addresses 6,7,0,1 with matching data on consecutive cycles.
- Read burst with a RAM model: RD_LAT=1 and RD_LAT=3, addr=6, len=3 → rsp_data 0x11,0x22,0x33,0x44 in order; rsp_valid first rises 3 (RD_LAT=1) or 5 (RD_LAT=3) cycles after the command handshake.
- Backpressure: hold rsp_ready=0 for 10 cycles during a read → rsp_valid and rsp_data stay stable, no further mem_re is issued, and the burst resumes on release.
- Reset mid-burst: assert rst during the third beat of an 8-beat write → all strobes go 0 asynchronously and busy=0; after release, cmd_ready=1 and a new read of addr 0 completes normally.
- Exclusivity: random command and stall stimulus for 10k cycles → mem_we & mem_re is never 1, and there is exactly one strobe per beat.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ram_burst_ctrl                                                  |
// | Purpose  : Burst write/read sequencer in front of a 2^AW x DW RAM. Accepts |
// |            commands over valid/ready, drives one RAM strobe per beat and   |
// |            returns read beats over a back-pressured response channel.      |
// |            RD_LAT is the RAM read latency and must lie in 1..4.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ram_burst_ctrl #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,        // asynchronous, active low
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          w_valid,
  output logic          w_ready,
  input  logic [DW-1:0] w_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // Wait counter wide enough for the largest legal read latency.
  localparam int                 c_CNT_W     = 3;
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [AW-1:0]        r_cur_addr;
  logic [AW-1:0]        r_beats_left;
  logic [c_CNT_W-1:0]   r_wait_cnt;

  logic                 w_cmd_hs;     // command accepted this cycle
  logic                 w_beat_hs;    // write beat accepted this cycle
  logic                 w_rsp_hs;     // response beat consumed this cycle
  logic                 w_wait_done;  // final cycle of the read latency window
  logic                 w_issue_set;  // a read strobe fires next cycle
  logic [AW-1:0]        w_issue_addr; // address for that read strobe
  logic                 w_last;       // current beat is the final one
  logic [AW-1:0]        w_addr_inc;

  assign w_last     = (r_beats_left == '0);
  assign w_addr_inc = r_cur_addr + 1'b1;

  // State register; reset forces IDLE immediately, even mid-burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode, handshake qualification and channel ready/valid.
  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    w_ready      = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    w_cmd_hs     = 1'b0;
    w_beat_hs    = 1'b0;
    w_rsp_hs     = 1'b0;
    w_wait_done  = 1'b0;
    w_issue_set  = 1'b0;
    w_issue_addr = w_addr_inc;

    case (r_state)
      S_IDLE: begin
        busy      = 1'b0;
        // Ready is suppressed while reset is held so no command is seen.
        cmd_ready = rst;
        if (cmd_valid) begin
          w_cmd_hs = 1'b1;
          if (cmd_wr) begin
            w_state_next = S_WRITE;
          end else begin
            w_state_next = S_ISSUE;
            w_issue_set  = 1'b1;
            w_issue_addr = cmd_addr;
          end
        end
      end

      S_WRITE: begin
        w_ready = 1'b1;
        if (w_valid) begin
          w_beat_hs = 1'b1;
          if (w_last) begin
            w_state_next = S_IDLE;
          end
        end
      end

      S_ISSUE: begin
        // The read strobe is already on the RAM pins during this cycle.
        w_state_next = S_WAIT;
      end

      S_WAIT: begin
        if (r_wait_cnt == c_WAIT_LAST) begin
          w_wait_done  = 1'b1;
          w_state_next = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_rsp_hs = 1'b1;
          if (w_last) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_ISSUE;
            w_issue_set  = 1'b1;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Burst bookkeeping: load on command, advance on every completed beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_addr   <= '0;
      r_beats_left <= '0;
    end else if (w_cmd_hs) begin
      r_cur_addr   <= cmd_addr;
      r_beats_left <= cmd_len;
    end else if (w_beat_hs || (w_rsp_hs && !w_last)) begin
      r_cur_addr <= w_addr_inc;
      if (!w_last) begin
        r_beats_left <= r_beats_left - 1'b1;
      end
    end
  end

  // RAM strobes: one-cycle pulses, address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= w_beat_hs;
      mem_re <= w_issue_set;
      if (w_beat_hs) begin
        mem_addr  <= r_cur_addr;
        mem_wdata <= w_data;
      end else if (w_issue_set) begin
        mem_addr <= w_issue_addr;
      end
    end
  end

  // Read latency counter, cleared whenever the FSM is outside WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Response data capture at the end of the latency window; held through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= '0;
    end else if (w_wait_done) begin
      rsp_data <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ram_burst_ctrl                                               |
// | Purpose  : Self-checking bench for ram_burst_ctrl with RD_LAT=1 (inst 0)   |
// |            and RD_LAT=3 (inst 1), each in front of a behavioural RAM.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic       cmd_wr    [2];
  logic [2:0] cmd_addr  [2];
  logic [2:0] cmd_len   [2];
  logic       w_valid   [2];
  logic       w_ready   [2];
  logic [7:0] w_data    [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_data  [2];
  logic [2:0] mem_addr  [2];
  logic       mem_we    [2];
  logic       mem_re    [2];
  logic [7:0] mem_wdata [2];
  logic [7:0] mem_rdata [2];
  logic       busy      [2];

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  [2] = '{0, 0};
  int re_cnt  [2] = '{0, 0};
  int overlap [2] = '{0, 0};
  int exp_we  [2] = '{0, 0};
  int exp_re  [2] = '{0, 0};
  logic [7:0] shadow [2][8];

  always #5 clk = ~clk;

  ram_burst_ctrl #(.DW(8), .AW(3), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_wr(cmd_wr[0]),
    .cmd_addr(cmd_addr[0]), .cmd_len(cmd_len[0]),
    .w_valid(w_valid[0]), .w_ready(w_ready[0]), .w_data(w_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_re(mem_re[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  ram_burst_ctrl #(.DW(8), .AW(3), .RD_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_wr(cmd_wr[1]),
    .cmd_addr(cmd_addr[1]), .cmd_len(cmd_len[1]),
    .w_valid(w_valid[1]), .w_ready(w_ready[1]), .w_data(w_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_re(mem_re[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Behavioural RAMs; data is valid only in the cycle RD_LAT after mem_re,
  // filler 0xEE appears otherwise so a mistimed capture is visible.
  logic [7:0] ram0 [8];
  logic [7:0] ram1 [8];
  logic [7:0] pipe0;
  logic [7:0] pipe1 [3];

  always @(posedge clk) begin
    if (mem_we[0]) ram0[mem_addr[0]] <= mem_wdata[0];
    if (mem_we[1]) ram1[mem_addr[1]] <= mem_wdata[1];
    pipe0    <= mem_re[0] ? ram0[mem_addr[0]] : 8'hEE;
    pipe1[0] <= mem_re[1] ? ram1[mem_addr[1]] : 8'hEE;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end

  always_comb begin
    mem_rdata[0] = pipe0;
    mem_rdata[1] = pipe1[2];
  end

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        if (mem_we[m] && mem_re[m]) overlap[m] <= overlap[m] + 1;
        if (mem_we[m]) we_cnt[m] <= we_cnt[m] + 1;
        if (mem_re[m]) re_cnt[m] <= re_cnt[m] + 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int k, input logic [2:0] a, input logic [2:0] l,
                          input logic [7:0] d0, input bit rnd);
    int         sent;
    int         guard;
    logic [7:0] d;
    logic [2:0] ea;
    bit         hs;
    check("wr_cmd_ready", 32'(cmd_ready[k]), 32'd1);
    cmd_valid[k] = 1'b1; cmd_wr[k] = 1'b1; cmd_addr[k] = a; cmd_len[k] = l;
    tick();
    cmd_valid[k] = 1'b0; cmd_wr[k] = 1'b0; cmd_addr[k] = ~a; cmd_len[k] = ~l;
    check("wr_busy", 32'(busy[k]), 32'd1);
    check("wr_cmd_blocked", 32'(cmd_ready[k]), 32'd0);
    sent  = 0;
    guard = 0;
    while (sent <= int'(l) && guard < 200) begin
      d = d0 + 8'(sent * 17);
      w_valid[k] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      w_data[k]  = w_valid[k] ? d : 8'($urandom);
      hs = w_valid[k] && w_ready[k];
      if (!rnd) check("wr_w_ready", 32'(w_ready[k]), 32'd1);
      tick();
      if (hs) begin
        ea = a + 3'(sent);
        check("wr_we", 32'(mem_we[k]), 32'd1);
        check("wr_addr", 32'(mem_addr[k]), 32'(ea));
        check("wr_data", 32'(mem_wdata[k]), 32'(d));
        shadow[k][ea] = d;
        exp_we[k]++;
        sent++;
      end else begin
        check("wr_no_we", 32'(mem_we[k]), 32'd0);
      end
      guard++;
    end
    w_valid[k] = 1'b0;
    check("wr_in_budget", 32'(guard < 200), 32'd1);
    check("wr_end_cmd_ready", 32'(cmd_ready[k]), 32'd1);
    check("wr_end_busy", 32'(busy[k]), 32'd0);
  endtask

  task automatic do_read(input int k, input logic [2:0] a, input logic [2:0] l,
                         input bit rnd, input int stall_beat, input int stall_n);
    int         lat;
    int         n;
    int         stall;
    int         re0;
    logic [2:0] ea;
    logic [7:0] held;
    lat = (k == 0) ? 1 : 3;
    check("rd_cmd_ready", 32'(cmd_ready[k]), 32'd1);
    cmd_valid[k] = 1'b1; cmd_wr[k] = 1'b0; cmd_addr[k] = a; cmd_len[k] = l;
    rsp_ready[k] = 1'b0;
    w_valid[k]   = 1'b1;          // must be ignored outside WRITE
    w_data[k]    = 8'h5A;
    tick();
    cmd_valid[k] = 1'b0; cmd_wr[k] = 1'b1; cmd_addr[k] = ~a; cmd_len[k] = ~l;
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 3'(i);
      check("rd_re", 32'(mem_re[k]), 32'd1);
      check("rd_re_addr", 32'(mem_addr[k]), 32'(ea));
      exp_re[k]++;
      n = 0;
      while (!rsp_valid[k] && n < 50) begin
        tick();
        n++;
      end
      check("rd_latency", 32'(n), 32'(lat + 1));
      check("rd_data", 32'(rsp_data[k]), 32'(shadow[k][ea]));
      stall = rnd ? int'($urandom_range(0, 3)) : ((i == stall_beat) ? stall_n : 0);
      held  = rsp_data[k];
      re0   = re_cnt[k];
      for (int s = 0; s < stall; s++) begin
        tick();
        check("rd_stall_valid", 32'(rsp_valid[k]), 32'd1);
        check("rd_stall_data", 32'(rsp_data[k]), 32'(held));
      end
      if (stall > 0) check("rd_stall_no_re", 32'(re_cnt[k]), 32'(re0));
      rsp_ready[k] = 1'b1;
      tick();
      rsp_ready[k] = 1'b0;
    end
    w_valid[k] = 1'b0;
    check("rd_end_cmd_ready", 32'(cmd_ready[k]), 32'd1);
    check("rd_end_busy", 32'(busy[k]), 32'd0);
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [2:0] len;
    logic [7:0] d0;
    logic [2:0] last_addr;   // hand-computed address of the final beat
    logic [7:0] last_data;   // hand-computed d0 + len*0x11
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{addr: 3'd2, len: 3'd0, d0: 8'hA5, last_addr: 3'd2, last_data: 8'hA5};
    vecs[1] = '{addr: 3'd6, len: 3'd3, d0: 8'h11, last_addr: 3'd1, last_data: 8'h44};
    vecs[2] = '{addr: 3'd0, len: 3'd7, d0: 8'h01, last_addr: 3'd7, last_data: 8'h78};
    vecs[3] = '{addr: 3'd7, len: 3'd1, d0: 8'h80, last_addr: 3'd0, last_data: 8'h91};
    vecs[4] = '{addr: 3'd5, len: 3'd4, d0: 8'hF0, last_addr: 3'd1, last_data: 8'h34};

    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0; cmd_wr[k] = 1'b0; cmd_addr[k] = '0; cmd_len[k] = '0;
      w_valid[k] = 1'b0; w_data[k] = '0; rsp_ready[k] = 1'b0;
    end

    // Reset state
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      check("rst_cmd_ready", 32'(cmd_ready[k]), 32'd0);
      check("rst_w_ready", 32'(w_ready[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check("rst_we_re", 32'({mem_we[k], mem_re[k]}), 32'd0);
      check("rst_addr", 32'(mem_addr[k]), 32'd0);
      check("rst_wdata", 32'(mem_wdata[k]), 32'd0);
      check("rst_rsp_data", 32'(rsp_data[k]), 32'd0);
    end
    rst = 1'b1;
    tick();

    // Fill both RAMs so every later read has a known expectation
    do_write(0, 3'd0, 3'd7, 8'h01, 1'b0);
    do_write(1, 3'd0, 3'd7, 8'h02, 1'b0);

    // Table-driven bursts: write, check held strobe values, read back (RD_LAT=1)
    foreach (vecs[v]) begin
      do_write(0, vecs[v].addr, vecs[v].len, vecs[v].d0, 1'b0);
      tick(); tick();
      check("hold_addr", 32'(mem_addr[0]), 32'(vecs[v].last_addr));
      check("hold_wdata", 32'(mem_wdata[0]), 32'(vecs[v].last_data));
      check("hold_no_we", 32'(mem_we[0]), 32'd0);
      do_read(0, vecs[v].addr, vecs[v].len, 1'b0, -1, 0);
    end

    // Wrapping burst through the RD_LAT=3 instance
    do_write(1, 3'd6, 3'd3, 8'h11, 1'b0);
    do_read(1, 3'd6, 3'd3, 1'b0, -1, 0);
    check("lat3_shadow_wrap", 32'(shadow[1][1]), 32'h44);

    // Backpressure: 10-cycle stall on the second beat
    do_write(0, 3'd6, 3'd3, 8'h11, 1'b0);
    do_read(0, 3'd6, 3'd3, 1'b0, 1, 10);

    // Reset during the third beat of an 8-beat write
    check("mid_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    cmd_valid[0] = 1'b1; cmd_wr[0] = 1'b1; cmd_addr[0] = 3'd0; cmd_len[0] = 3'd7;
    tick();
    cmd_valid[0] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      w_valid[0] = 1'b1;
      w_data[0]  = 8'hC0 + 8'(b);
      tick();
    end
    shadow[0][0] = 8'hC0;
    shadow[0][1] = 8'hC1;
    exp_we[0] += 2;
    check("mid_pre_we", 32'(mem_we[0]), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_async_we", 32'(mem_we[0]), 32'd0);
    check("mid_async_re", 32'(mem_re[0]), 32'd0);
    check("mid_async_busy", 32'(busy[0]), 32'd0);
    check("mid_async_addr", 32'(mem_addr[0]), 32'd0);
    check("mid_async_wdata", 32'(mem_wdata[0]), 32'd0);
    check("mid_async_cmd_ready", 32'(cmd_ready[0]), 32'd0);
    check("mid_async_w_ready", 32'(w_ready[0]), 32'd0);
    tick();
    check("mid_hold_we", 32'(mem_we[0]), 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rel_cmd_ready", 32'(cmd_ready[0]), 32'd1);
    check("mid_rel_busy", 32'(busy[0]), 32'd0);
    check("mid_rel_we", 32'(mem_we[0]), 32'd0);
    w_valid[0] = 1'b0;
    do_read(0, 3'd0, 3'd2, 1'b0, -1, 0);

    // Random commands, gaps and stalls on both instances
    for (int it = 0; it < 500; it++) begin
      int         k;
      logic [2:0] a;
      logic [2:0] l;
      k = it % 2;
      a = 3'($urandom);
      l = 3'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(k, a, l, 8'($urandom), 1'b1);
      else                           do_read(k, a, l, 1'b1, -1, 0);
    end

    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      check("excl_overlap", 32'(overlap[k]), 32'd0);
      check("excl_we_count", 32'(we_cnt[k]), 32'(exp_we[k]));
      check("excl_re_count", 32'(re_cnt[k]), 32'(exp_re[k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
